// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for lock with timeout/retry, then settles before releasing the design.
// Outputs are decoded straight from one-hot state flops so sys_rst/ready/pll_rst never glitch.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1000000,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] retries
);

  localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CNT = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  localparam int unsigned IDX_PLL_RESET = 0;
  localparam int unsigned IDX_RUN       = 3;

  typedef enum logic [3:0] {
    ST_PLL_RESET = 4'b0001,
    ST_WAIT_LOCK = 4'b0010,
    ST_SETTLE    = 4'b0100,
    ST_RUN       = 4'b1000
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             retries_q, retries_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_PLL_RESET;
      cnt_q     <= '0;
      retries_q <= '0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    retries_d = retries_q;
    unique case (state_q)
      ST_PLL_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_PLL_RESET;
          cnt_d   = '0;
          if (retries_q != 8'hFF) retries_d = retries_q + 8'd1;
        end
      end
      ST_SETTLE: begin
        // Any synchronized drop restarts the whole settle window from WAIT_LOCK.
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_PLL_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  assign pll_rst = state_q[IDX_PLL_RESET];
  assign ready   = state_q[IDX_RUN];
  assign sys_rst = ~state_q[IDX_RUN];
  assign retries = retries_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expected output snapshots are queued per clock edge index
// (edges counted since reset release) and compared at the following falling edge.
module tb_pll_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst, ready;
  logic [7:0] retries;

  pll_reset_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .SETTLE_CYCLES(8), .SYNC_STAGES(2)
  ) dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .retries(retries)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [10:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic prst, input logic srst, input logic rdy,
                      input logic [7:0] ret, input string tag);
    exp_t e;
    e.cyc = c;
    e.exp = {prst, srst, rdy, ret};
    e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check_eq(e.tag, {21'd0, pll_rst, sys_rst, ready, retries}, {21'd0, e.exp});
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    check_eq(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Lock present from the start: 4-cycle PLL pulse, release after edge 13.
    pll_locked = 1'b1;
    do_reset();
    push(0, 1, 1, 0, 0, "a_reset_state");
    push(3, 1, 1, 0, 0, "a_pllrst_last");
    push(4, 0, 1, 0, 0, "a_pllrst_fall");
    push(12, 0, 1, 0, 0, "a_settle_end");
    push(13, 0, 0, 1, 0, "a_run");
    run_to(14);
    drain("a_drain");

    // One-cycle glitch during SETTLE at cnt==5, then loss of lock in RUN.
    pll_locked = 1'b1;
    do_reset();
    for (int c = 0; c < 4; c++) push(c, 1, 1, 0, 0, "b_pllrst");
    for (int c = 4; c <= 20; c++) push(c, 0, 1, 0, 0, "b_held");
    push(21, 0, 0, 1, 0, "b_run");
    push(27, 0, 0, 1, 0, "b_run_before_loss");
    for (int c = 28; c <= 40; c++) push(c, 0, 1, 0, 0, "b_relock");
    push(41, 0, 0, 1, 0, "b_rerun");
    run_to(9);
    pll_locked = 1'b0;
    run_to(10);
    pll_locked = 1'b1;
    run_to(25);
    pll_locked = 1'b0;
    run_to(30);
    pll_locked = 1'b1;
    run_to(42);
    drain("b_drain");

    // Three timeouts, then lock; asynchronous reset mid-SETTLE clears everything.
    pll_locked = 1'b0;
    do_reset();
    push(72, 1, 1, 0, 3, "c_third_retry");
    push(78, 0, 1, 0, 3, "c_settle");
    run_to(72);
    pll_locked = 1'b1;
    run_to(80);
    drain("c_drain");
    #1 reset = 1'b1;
    #1;
    check_eq("c_async_rst", {28'd0, pll_rst, sys_rst, ready, 1'b0}, {28'd0, 4'b1100});
    check_eq("c_async_retries", {24'd0, retries}, 32'd0);

    // No lock ever: 24-cycle retry period, retries saturating at 255.
    pll_locked = 1'b0;
    do_reset();
    for (int p = 0; p <= 260; p++) begin
      automatic logic [7:0] r = (p > 255) ? 8'd255 : 8'(p);
      push(24 * p,      1, 1, 0, r, "d_pulse_start");
      push(24 * p + 3,  1, 1, 0, r, "d_pulse_end");
      push(24 * p + 4,  0, 1, 0, r, "d_wait_start");
      push(24 * p + 23, 0, 1, 0, r, "d_wait_end");
    end
    run_to(24 * 260 + 24);
    drain("d_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
